// File: rtl/mem_if_pkg.sv
// Shared definitions for the lane-array memory initiator: FSM state
// encodings and the default lane geometry.
package mem_if_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int LANES_DEF  = 4;
  localparam int LANE_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_lane_initiator.sv
// Initiator for the byte-lane memory array. Converts a valid/ready request
// stream into level-sensitive read/write strobes and returns read data on a
// valid/ready response channel.
//
// state | meaning
// IDLE  | waiting for a request; strobes low, req_ready high
// WRITE | single cycle with per-lane write strobes asserted (posted write)
// READ  | mem_read held for READ_LAT cycles, data sampled on the last edge
// RESP  | read data held on rsp_rdata until the consumer takes it
module mem_lane_initiator
  import mem_if_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LANES    = LANES_DEF,
  parameter int LANE_W   = LANE_W_DEF,
  parameter int READ_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [LANES*LANE_W-1:0] req_wdata,
  input  logic [LANES-1:0]        req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [LANES*LANE_W-1:0] rsp_rdata,
  output logic                    mem_read,
  output logic [LANES-1:0]        mem_write,
  output logic [ADDR_W-1:0]       mem_address,
  output logic [LANES*LANE_W-1:0] mem_data_in,
  input  logic [LANES*LANE_W-1:0] mem_data_out,
  output logic [7:0]              txn_count
);

  localparam int DATA_W = LANES * LANE_W;
  // The counter holds the number of READ cycles still to go after the current one.
  localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                mem_read_q, mem_read_d;
  logic [LANES-1:0]    mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_data_in_q, mem_data_in_d;
  logic [7:0]          txn_count_q, txn_count_d;

  // Next-state and registered-output computation for the sequencing FSM.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    txn_count_d   = txn_count_q;

    case (state_q)
      ST_IDLE: begin
        // Address and write data only ever move here, while no strobe is active.
        if (req_valid && req_ready_q) begin
          mem_address_d = req_addr;
          mem_data_in_d = req_wdata;
          if (req_we) begin
            state_d     = ST_WRITE;
            mem_write_d = req_be;
          end else begin
            state_d    = ST_READ;
            mem_read_d = 1'b1;
            cnt_d      = LAT_M1;
          end
        end
      end
      ST_WRITE: begin
        mem_write_d = '0;
        txn_count_d = txn_count_q + 8'd1;
        state_d     = ST_IDLE;
      end
      ST_READ: begin
        if (cnt_q == 4'd0) begin
          rsp_rdata_d = mem_data_out;
          mem_read_d  = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          txn_count_d = txn_count_q + 8'd1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = '0;
        rsp_valid_d = 1'b0;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset drops strobes and discards any response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= '0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      txn_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      txn_count_q   <= txn_count_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  assign txn_count   = txn_count_q;

endmodule
